// File: rtl/tt_io_selftest_pkg.sv
// Shared types and PRBS7 helper for the I/O self-test engine.
// Imported by the parallel PRBS block and the top.
package tt_selftest_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_COUNT = 2'd1,
        MODE_PRBS  = 2'd2,
        MODE_LOOP  = 2'd3
    } mode_e;

    localparam logic ST_SEARCH = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    // x^7 + x^6 + 1 taps, as bit positions of the 7-bit state
    localparam int PRBS_TAP_HI = 6;
    localparam int PRBS_TAP_LO = 5;

    function automatic logic [6:0] prbs7_step(input logic [6:0] state, input int nbits);
        logic [6:0] s;
        s = state;
        for (int i = 0; i < nbits; i++) begin
            s = {s[5:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
        end
        return s;
    endfunction

endpackage

// File: rtl/tt_io_selftest_if.sv
// Pattern bus between the self-test engine and whatever drives its controls.
// The master side owns controls and rx; the slave side (the engine) owns tx and status.
interface tt_io_selftest_if #(
    parameter int DATA_W = 8,
    parameter int ERR_W  = 8
);
    logic              ena;
    logic [1:0]        mode;
    logic              start;
    logic [DATA_W-1:0] rx_data;
    logic [DATA_W-1:0] tx_data;
    logic              tx_oe;
    logic              locked;
    logic [ERR_W-1:0]  err_cnt;

    modport master (
        output ena, mode, start, rx_data,
        input  tx_data, tx_oe, locked, err_cnt
    );

    modport slave (
        input  ena, mode, start, rx_data,
        output tx_data, tx_oe, locked, err_cnt
    );
endinterface

// File: rtl/tt_io_selftest_prbs_par.sv
// Combinational PRBS7 advance by DATA_W serial steps; the first bit produced
// lands in the MSB, the newest in bit 0, so word[6:0] is the advanced state.
module tt_prbs_par
    import tt_selftest_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [6:0]        state,
    output logic [DATA_W-1:0] word
);

    logic [6:0] s;

    always_comb begin
        s    = state;
        word = '0;
        for (int i = 0; i < DATA_W; i++) begin
            s = prbs7_step(s, 1);
            word[DATA_W-1-i] = s[0];
        end
    end

endmodule

// File: rtl/tt_io_selftest.sv
// I/O bring-up engine: generates counter/PRBS7/loopback patterns on tx and
// checks the received pattern with a self-synchronising lock FSM.
module tt_io_selftest
    import tt_selftest_pkg::*;
#(
    parameter int         DATA_W     = 8,
    parameter int         ERR_W      = 8,
    parameter int         LOCK_CNT   = 16,
    parameter int         UNLOCK_CNT = 4,
    parameter logic [6:0] PRBS_SEED  = 7'h7F
) (
    input logic            clk,
    input logic            rst_n,
    tt_io_selftest_if.slave bus
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

    mode_e             mode;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] tx_q;
    logic              oe_q;
    logic [6:0]        gen_state;
    logic [6:0]        gen_src;
    logic [DATA_W-1:0] gen_word;
    logic [DATA_W-1:0] rx_q;
    logic [DATA_W-1:0] pred_word;
    logic [DATA_W-1:0] expected;
    logic              valid;
    logic              lock_state;
    logic [RUN_W-1:0]  run_cnt;
    logic [MISS_W-1:0] miss_cnt;
    logic [ERR_W-1:0]  err_q;
    logic              restart;
    logic              check_en;
    logic              match;

    assign mode     = mode_e'(bus.mode);
    assign restart  = bus.ena & (bus.start | (bus.mode != mode_q));
    assign check_en = (mode == MODE_COUNT) | (mode == MODE_PRBS);
    assign gen_src  = (gen_state == 7'd0) ? PRBS_SEED : gen_state;

    tt_prbs_par #(.DATA_W(DATA_W)) u_gen_prbs (
        .state (gen_src),
        .word  (gen_word)
    );

    // The checker predicts from the previous received word, so it re-syncs
    // on its own after any corruption without needing the generator state.
    tt_prbs_par #(.DATA_W(DATA_W)) u_chk_prbs (
        .state (rx_q[6:0]),
        .word  (pred_word)
    );

    always_comb begin
        expected = (mode == MODE_COUNT) ? rx_q + DATA_W'(1) : pred_word;
    end

    assign match = valid & (bus.rx_data == expected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q      <= '0;
            oe_q      <= 1'b0;
            gen_state <= PRBS_SEED;
            mode_q    <= 2'd0;
        end else begin
            oe_q <= bus.ena & (mode != MODE_IDLE);
            if (bus.ena) begin
                mode_q <= bus.mode;
                if (restart) begin
                    tx_q      <= '0;
                    gen_state <= PRBS_SEED;
                end else begin
                    case (mode)
                        MODE_COUNT: tx_q <= tx_q + DATA_W'(1);
                        MODE_PRBS: begin
                            tx_q      <= gen_word;
                            gen_state <= gen_word[6:0];
                        end
                        MODE_LOOP:  tx_q <= bus.rx_data;
                        default:    tx_q <= '0;
                    endcase
                end
            end
        end
    end

    // Lock FSM: errors are only counted once locked, and err_q survives a
    // drop back to SEARCH so bring-up can see how bad the link was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q       <= '0;
            valid      <= 1'b0;
            lock_state <= ST_SEARCH;
            run_cnt    <= '0;
            miss_cnt   <= '0;
            err_q      <= '0;
        end else if (bus.ena) begin
            rx_q <= bus.rx_data;
            if (restart) begin
                valid      <= 1'b0;
                lock_state <= ST_SEARCH;
                run_cnt    <= '0;
                miss_cnt   <= '0;
                if (bus.start) begin
                    err_q <= '0;
                end
            end else begin
                valid <= 1'b1;
                if (!check_en) begin
                    lock_state <= ST_SEARCH;
                    run_cnt    <= '0;
                    miss_cnt   <= '0;
                end else if (lock_state == ST_SEARCH) begin
                    if (!match) begin
                        run_cnt <= '0;
                    end else if (run_cnt == RUN_W'(LOCK_CNT - 1)) begin
                        lock_state <= ST_LOCKED;
                        run_cnt    <= '0;
                        miss_cnt   <= '0;
                    end else begin
                        run_cnt <= run_cnt + RUN_W'(1);
                    end
                end else if (match) begin
                    miss_cnt <= '0;
                end else begin
                    if (err_q != '1) begin
                        err_q <= err_q + ERR_W'(1);
                    end
                    if (miss_cnt == MISS_W'(UNLOCK_CNT - 1)) begin
                        lock_state <= ST_SEARCH;
                        run_cnt    <= '0;
                        miss_cnt   <= '0;
                    end else begin
                        miss_cnt <= miss_cnt + MISS_W'(1);
                    end
                end
            end
        end
    end

    assign bus.tx_data = tx_q;
    assign bus.tx_oe   = oe_q;
    assign bus.locked  = lock_state;
    assign bus.err_cnt = err_q;

endmodule
